// File: rtl/regfile_storage_if.sv
// regfile_storage_if: write-side bus of the register file storage array.
// Signals: clr, wr_en, wr_addr[4:0], wr_data[WIDTH-1:0]; master drives, slave samples.
interface regfile_storage_if #(
  parameter int WIDTH = 64
);
  logic             clr;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output clr,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input clr,
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/regfile_storage.sv
// regfile_storage: 32 x WIDTH register array, one decoded write port, reg 31 reads zero.
// Ports: clk, reset_n, wr (slave: clr/wr_en/wr_addr/wr_data), regs_q, written, wr_count.
// Optional REGFILE_BYPASS_EN: regs_q forwards wr_data into the slice being written.
module regfile_storage #(
  parameter int WIDTH = 64,
  parameter int NREG  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_storage_if.slave      wr,
  output logic [NREG*WIDTH-1:0] regs_q,
  output logic [NREG-1:0]       written,
  output logic [7:0]            wr_count
);

  localparam int ZREG = NREG - 1;

  logic [WIDTH-1:0] mem [ZREG];
  logic [NREG-1:0]  dec;
  logic             accept;

  // wr_en gates the decode first, so an unknown
  // address with wr_en low selects nothing.
  always_comb begin
    dec = '0;
    if (wr.wr_en) begin
      if (wr.wr_addr != 5'(ZREG)) begin
        dec[wr.wr_addr] = 1'b1;
      end
    end
  end

  assign accept = |dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ZREG; r++) begin
        mem[r] <= '0;
      end
      written  <= '0;
      wr_count <= '0;
    end else if (wr.clr) begin
      for (int r = 0; r < ZREG; r++) begin
        mem[r] <= '0;
      end
      written  <= '0;
      wr_count <= '0;
    end else begin
      for (int r = 0; r < ZREG; r++) begin
        if (dec[r]) begin
          mem[r] <= wr.wr_data;
        end
      end
      written <= written | dec;
      if (accept && wr_count != 8'hFF) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

  always_comb begin
    regs_q = '0;
    for (int r = 0; r < ZREG; r++) begin
      regs_q[r*WIDTH +: WIDTH] = mem[r];
`ifdef REGFILE_BYPASS_EN
      if (dec[r] && !wr.clr) begin
        regs_q[r*WIDTH +: WIDTH] = wr.wr_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_storage.sv
// tb_regfile_storage: directed vector table plus hand sequences
// for reset, clear priority, saturation and write-through.
module tb_regfile_storage;

  localparam int W = 64;
  localparam int N = 32;

  logic             clk;
  logic             reset_n;
  logic [N*W-1:0]   regs_q;
  logic [N-1:0]     written;
  logic [7:0]       wr_count;

  int checks;
  int errors;

  regfile_storage_if #(.WIDTH(W)) bus ();

  regfile_storage #(.WIDTH(W), .NREG(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (bus.slave),
    .regs_q   (regs_q),
    .written  (written),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    int          chk_idx;
    logic [63:0] exp_slice;
    logic [31:0] exp_written;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [63:0] slice(input int r);
    return regs_q[r*W +: W];
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic we,
                       input logic [4:0] a, input logic [63:0] d);
    bus.clr     = c;
    bus.wr_en   = we;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  logic [63:0] model [31];
  logic [63:0] byp_exp;
  logic [4:0]  xaddr;

  initial begin
    checks = 0;
    errors = 0;
    xaddr  = 'x;

    vecs[0] = '{1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5,
                64'hDEADBEEF_CAFEF00D, 32'h0000_0020, 8'd1};
    vecs[1] = '{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 31,
                64'h0, 32'h0000_0020, 8'd1};
    vecs[2] = '{1'b0, 1'b0, xaddr, 64'h1111, 5,
                64'hDEADBEEF_CAFEF00D, 32'h0000_0020, 8'd1};
    vecs[3] = '{1'b0, 1'b1, 5'd5, 64'h1, 5,
                64'h1, 32'h0000_0020, 8'd2};
    vecs[4] = '{1'b0, 1'b1, 5'd5, 64'h2, 5,
                64'h2, 32'h0000_0020, 8'd3};
    vecs[5] = '{1'b0, 1'b1, 5'd0, 64'h55, 0,
                64'h55, 32'h0000_0021, 8'd4};
    vecs[6] = '{1'b1, 1'b1, 5'd3, 64'h1234, 3,
                64'h0, 32'h0000_0000, 8'd0};
    vecs[7] = '{1'b0, 1'b1, 5'd30, 64'hAA, 30,
                64'hAA, 32'h4000_0000, 8'd1};
    vecs[8] = '{1'b0, 1'b0, 5'd7, 64'h77, 7,
                64'h0, 32'h4000_0000, 8'd1};

    drive(1'b0, 1'b0, 5'd0, 64'h0);
    reset_n = 1'b0;
    #12;
    check("reset_regs", 64'(regs_q != '0), 64'h0);
    check("reset_written", 64'(written), 64'h0);
    check("reset_count", 64'(wr_count), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].clr, vecs[i].we, vecs[i].addr, vecs[i].data);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 64'h0);
      check($sformatf("vec%0d_slice", i), slice(vecs[i].chk_idx),
            vecs[i].exp_slice);
      check($sformatf("vec%0d_written", i), 64'(written),
            64'(vecs[i].exp_written));
      check($sformatf("vec%0d_count", i), 64'(wr_count),
            64'(vecs[i].exp_count));
      if (i == 0) begin
        for (int r = 0; r < N; r++) begin
          if (r != 5) check($sformatf("basic_other%0d", r), slice(r), 64'h0);
        end
      end
    end

    // reset pulse mid-cycle with live state, no clock edge
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_slice30", slice(30), 64'h0);
    check("midreset_written", 64'(written), 64'h0);
    check("midreset_count", 64'(wr_count), 64'h0);
    #1;
    reset_n = 1'b1;

    // reset held across a write edge drops the write
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd9, 64'h9999);
    #3;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 64'h0);
    check("rstwr_slice9", slice(9), 64'h0);
    check("rstwr_written", 64'(written), 64'h0);
    check("rstwr_count", 64'(wr_count), 64'h0);

    // saturation: 300 writes over 0..30
    for (int r = 0; r < 31; r++) model[r] = 64'h0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 5'(i % 31), 64'(i + 1) ^ 64'hA5A5_0000_0000_0000);
      model[i % 31] = 64'(i + 1) ^ 64'hA5A5_0000_0000_0000;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 64'h0);
    check("sat_count", 64'(wr_count), 64'd255);
    check("sat_written", 64'(written), 64'h7FFF_FFFF);
    for (int r = 0; r < 31; r++) begin
      check($sformatf("sat_reg%0d", r), slice(r), model[r]);
    end
    check("sat_reg31", slice(31), 64'h0);

    // clear, seed reg 7, then look at it during the next write cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd7, 64'h1111);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd7, 64'hABCD);
    #1;
`ifdef REGFILE_BYPASS_EN
    byp_exp = 64'hABCD;
`else
    byp_exp = 64'h1111;
`endif
    check("bypass_same_cycle", slice(7), byp_exp);
    check("bypass_count_same", 64'(wr_count), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 64'h0);
    check("bypass_next_cycle", slice(7), 64'hABCD);
    check("bypass_count_next", 64'(wr_count), 64'd2);
    check("bypass_written", 64'(written), 64'h0000_0080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
